seg_scan_ctrl: RTL
==================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexing scheduler for the shared 7-segment decoder and the digit anodes.
//  Selects one enabled digit at a time and routes its 4-bit value to the decoder.
//  Inserts an all-off blanking gap before each digit switch to suppress ghosting.
//  Sits between the switch/adder datapath (digit values) and segmentlogic.
// PARAMETERS
//  DIGITS     2     number of multiplexed digits (2..8)
//  DWELL_CYC  4096  clk cycles one digit is driven per visit (>=2)
//  BLANK_CYC  64    clk cycles all anodes are off before each visit (>=1)
// PORTS
//  clk         in   1         system clock
//  reset       in   1         asynchronous, active-low reset
//  digit_val   in   4*DIGITS  hex value per digit; digit k = [4k+3:4k]
//  digit_en    in   DIGITS    1 = digit k takes part in the scan
//  duty        in   4         on-time in 1/16ths of DWELL_CYC (SCAN_PWM_EN builds only)
//  s           out  4         value to segmentlogic for the driven digit
//  anode_n     out  DIGITS    active-low anode enables; at most one bit low
//  frame_start out  1         1-cycle pulse when the scan wraps to the lowest enabled digit
// BEHAVIOUR
//  - Reset (async assert, sync release): state=S_IDLE, idx=0, cnt=0, anode_n='1, s=0, frame_start=0.
//  - All outputs registered; s and anode_n update on the same edge.
//  - States (in seg_scan_pkg):
//    S_IDLE:  no digit_en bit set; anode_n='1. Leaves for S_BLANK the cycle after any digit_en bit is set.
//    S_BLANK: anode_n='1 for exactly BLANK_CYC cycles.
//             On the last cycle, choose next idx = first enabled digit strictly after the
//             current idx, wrapping DIGITS-1 -> 0 (the current idx is chosen if it is the
//             only enabled digit). No enabled digits -> S_IDLE.
//    S_DRIVE: entered with s <= digit_val[idx], sampled once on entry and held for the visit.
//             anode_n[idx] is low for DWELL_CYC cycles, then the block goes to S_BLANK.
//  - frame_start: pulses on entry to S_DRIVE when the chosen idx is numerically <= the
//    previous idx (wrap), and on the first S_DRIVE after S_IDLE.
//  - digit_en changes mid-visit do not cut the visit short; they take effect at the next selection.
//  - digit_val changes mid-visit do not reach s until the next visit.
//  - cnt is a down-counter of width clog2(max(DWELL_CYC,BLANK_CYC)), reloaded on every state entry.
//  - Scan period per digit = BLANK_CYC + DWELL_CYC cycles; no idle cycles between states.
//  - Reset asserted mid-visit: anode_n goes to '1 immediately (asynchronously).
// CONFIGURATION
//  SCAN_PWM_EN defined:
//    - In S_DRIVE, anode_n[idx] is low only while elapsed < (duty*DWELL_CYC)/16.
//    - Integer floor is used; duty=0 gives a fully dark visit.
//    - Visit length, s timing and frame_start are unchanged.
//  SCAN_PWM_EN undefined:
//    - duty is ignored (port is kept); full-dwell drive.
// STRUCTURE
//  seg_scan_pkg: scan_state_t enum {S_IDLE,S_BLANK,S_DRIVE}; ANODE_OFF constant; next_enabled() function.
//  One sub-module, scan_pick: combinational round-robin next-enabled-index finder
//  (inputs digit_en, idx; outputs nxt_idx, any_en).
//  FSM, counter and output registers live in seg_scan_ctrl.
// TESTING  (DIGITS=2, DWELL_CYC=8, BLANK_CYC=2)
//  1. Reset low, then release with en=2'b11, val=8'h3A
//     -> 2 blank cycles; anode_n=2'b10 with s=A for 8 cycles; 2 blank cycles;
//        anode_n=2'b01 with s=3 for 8 cycles; frame_start pulses at each visit to digit 0.
//  2. en=2'b01 -> only digit 0 is driven: 8 on / 2 off, repeating; s stays at digit 0's value.
//  3. en=2'b00 from the start -> S_IDLE, anode_n=2'b11. Set en=2'b10
//     -> blank 2 cycles, then digit 1 driven, frame_start=1.
//  4. Change val on cycle 3 of a visit -> s unchanged until the next visit of that digit.
//  5. Assert reset mid-S_DRIVE -> anode_n=2'b11 and s=0 in the same cycle, without a clock edge.
//  6. SCAN_PWM_EN, duty=4 -> anode low for 2 of 8 dwell cycles; duty=0 -> never low.
//     Visit timing is unchanged in both cases.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// seg_scan_pkg: scan states, anode-off constant and round-robin next-enabled helper
package seg_scan_pkg;
  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} scan_state_t;
  localparam logic [7:0] ANODE_OFF = 8'hFF;
  function automatic logic [2:0] next_enabled(logic [7:0] en, logic [2:0] idx, int n);
    logic [2:0] r;
    logic hit;
    int j;
    r = idx;
    hit = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      j = (int'(idx) + k) % n;
      if (k <= n && !hit && en[j]) begin
        r = 3'(j);
        hit = 1'b1;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: digit values/enables/duty in, decoder value, anodes and frame pulse out
interface seg_scan_ctrl_if #(parameter int DIGITS = 2);
  logic [4*DIGITS-1:0] digit_val;
  logic [DIGITS-1:0]   digit_en;
  logic [3:0]          duty;
  logic [3:0]          s;
  logic [DIGITS-1:0]   anode_n;
  logic                frame_start;
  modport master(output digit_val, digit_en, duty, input s, anode_n, frame_start);
  modport slave(input digit_val, digit_en, duty, output s, anode_n, frame_start);
endinterface

// File: rtl/seg_scan_ctrl_pick.sv
// scan_pick: combinational round-robin finder of the next enabled digit after idx
module scan_pick import seg_scan_pkg::*; #(
  parameter int DIGITS = 2,
  localparam int IW = $clog2(DIGITS)
) (
  input  logic [DIGITS-1:0] digit_en,
  input  logic [IW-1:0]     idx,
  output logic [IW-1:0]     nxt_idx,
  output logic              any_en
);
  logic [2:0] full;
  assign full = next_enabled(8'(digit_en), 3'(idx), DIGITS);
  assign nxt_idx = full[IW-1:0];
  assign any_en = |digit_en;
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: blanked round-robin 7-segment digit scanner; SCAN_PWM_EN adds duty-cycle dimming
module seg_scan_ctrl import seg_scan_pkg::*; #(
  parameter int DIGITS = 2,
  parameter int DWELL_CYC = 4096,
  parameter int BLANK_CYC = 64
) (
  input logic clk,
  input logic rst_n,
  seg_scan_ctrl_if.slave bus
);
  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(DWELL_CYC > BLANK_CYC ? DWELL_CYC : BLANK_CYC);
  localparam logic [DIGITS-1:0] OFF = ANODE_OFF[DIGITS-1:0];
  scan_state_t state, nstate;
  logic [IW-1:0] idx, nidx, pick;
  logic [CW-1:0] cnt, ncnt;
  logic [3:0] s_q, ns;
  logic [DIGITS-1:0] an_q, nan;
  logic fs_q, nfs, first, nfirst, any_en;
  int on_cyc;
`ifdef SCAN_PWM_EN
  assign on_cyc = (int'(bus.duty) * DWELL_CYC) / 16;
`else
  logic unused_duty;
  assign unused_duty = ^bus.duty;
  assign on_cyc = DWELL_CYC;
`endif
  function automatic logic [DIGITS-1:0] drive(logic [IW-1:0] i, logic [CW-1:0] c, int on);
    return (DWELL_CYC - 1 - int'(c) < on) ? OFF ^ (DIGITS'(1) << i) : OFF;
  endfunction
  // after idle the scan restarts at the lowest enabled digit: search from DIGITS-1
  scan_pick #(.DIGITS(DIGITS)) u_pick (
    .digit_en(bus.digit_en),
    .idx(first ? IW'(DIGITS - 1) : idx),
    .nxt_idx(pick),
    .any_en(any_en)
  );
  always_comb begin
    nstate = state;
    ncnt = cnt;
    nidx = idx;
    ns = s_q;
    nan = OFF;
    nfs = 1'b0;
    nfirst = first;
    case (state)
      S_IDLE: begin
        nfirst = 1'b1;
        if (|bus.digit_en) begin
          nstate = S_BLANK;
          ncnt = CW'(BLANK_CYC - 1);
        end
      end
      S_BLANK:
        if (cnt != '0) ncnt = cnt - 1'b1;
        else if (!any_en) begin
          nstate = S_IDLE;
          ncnt = '0;
        end else begin
          nstate = S_DRIVE;
          ncnt = CW'(DWELL_CYC - 1);
          nidx = pick;
          ns = bus.digit_val[{pick, 2'b00} +: 4];
          nfs = first || pick <= idx;
          nfirst = 1'b0;
          nan = drive(pick, CW'(DWELL_CYC - 1), on_cyc);
        end
      S_DRIVE:
        if (cnt != '0) begin
          ncnt = cnt - 1'b1;
          nan = drive(idx, cnt - 1'b1, on_cyc);
        end else begin
          nstate = S_BLANK;
          ncnt = CW'(BLANK_CYC - 1);
        end
      default: nstate = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      idx <= '0;
      cnt <= '0;
      s_q <= '0;
      an_q <= OFF;
      fs_q <= 1'b0;
      first <= 1'b1;
    end else begin
      state <= nstate;
      idx <= nidx;
      cnt <= ncnt;
      s_q <= ns;
      an_q <= nan;
      fs_q <= nfs;
      first <= nfirst;
    end
  assign bus.s = s_q;
  assign bus.anode_n = an_q;
  assign bus.frame_start = fs_q;
endmodule
